uart_core_param: RTL and testbench

- Parametrised successor to the fixed 8N1 uartController: full-duplex UART with configurable data width, parity and stop bits, and a small TX FIFO.
- Adds a valid/ready TX handshake, per-frame RX error flags, glitch-rejecting start detection and a switchable internal loopback.
- Sits between board pins (e.g. the header RX/TX lines to the Raspberry Pi) and user logic in the top level.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_core_param.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and parity helper for the UART core
// Purpose: parity mode constants, TX/RX FSM encodings and a parity function
//          used by uart_core_param.
// Ports  : none (package).
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Parity bit that accompanies the low nbits of word: odd = ~^data, even = ^data.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word,
                                      input int nbits, input int mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nbits) x = x ^ word[i];
    end
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - small synchronous FIFO with extra-MSB pointers
// Purpose: TX word queue in front of the UART transmitter.
// Ports  : clk, rst (sync, active-high); i_push/i_data write side;
//          i_pop/o_data read side (o_data shows the head word);
//          o_full, o_empty status derived from pointer compare.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Same index with differing wrap bit means the write side lapped the read side.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop && !o_empty) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART with TX FIFO and loopback
// Purpose: serialises FIFO words onto tx_pin and deserialises rx_pin frames
//          with parity/stop checking and glitch-rejecting start detection.
// Ports  : clk, rst (sync, active-high); rx_pin/tx_pin serial lines;
//          tx_data/tx_valid/tx_ready/tx_busy transmit side;
//          rx_data/rx_valid/rx_parity_err/rx_frame_err receive side;
//          loopback selects internal TX->RX routing.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  input  logic                 loopback
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_fifo_pop;
  logic [DATA_BITS-1:0]     w_fifo_data;
  logic [MAX_DATA_BITS-1:0] w_fifo_ext;
  logic [MAX_DATA_BITS-1:0] w_rx_ext;
  logic                     w_rx_src;

  tx_state_t            r_tx_state;
  logic [CW-1:0]        r_tx_baud;
  logic [BW-1:0]        r_tx_bits;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;

  rx_state_t            r_rx_state;
  logic [CW-1:0]        r_rx_baud;
  logic [BW-1:0]        r_rx_bits;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_bit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_perr;
  logic                 r_rx_ferr;
  logic                 r_rx_done;
  logic                 r_rx_valid;

  logic r_loopback;
  logic r_sync1;
  logic r_sync2;

  assign w_fifo_pop = (r_tx_state == TX_IDLE) && !w_fifo_empty;
  assign w_fifo_ext = MAX_DATA_BITS'(w_fifo_data);
  assign w_rx_ext   = MAX_DATA_BITS'(r_rx_shift);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign tx_ready      = !w_fifo_full;
  assign tx_busy       = (r_tx_state != TX_IDLE) || !w_fifo_empty;
  assign tx_pin        = r_loopback ? 1'b1 : r_tx_line;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;

  // Transmitter: the IDLE cycle that pops is the only gap between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (!w_fifo_empty) begin
            r_tx_shift <= w_fifo_data;
            r_tx_par   <= parity_bit(w_fifo_ext, DATA_BITS, PARITY);
            r_tx_line  <= 1'b0;
            r_tx_baud  <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_baud <= r_tx_baud + CW'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud <= '0;
            if (r_tx_bits == DATA_LAST) begin
              r_tx_bits <= '0;
              if (PARITY != PAR_NONE) begin
                r_tx_line  <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx_line  <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_bits  <= r_tx_bits + BW'(1);
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_baud <= r_tx_baud + CW'(1);
          end
        end
        TX_PARITY: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_line  <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_baud <= r_tx_baud + CW'(1);
          end
        end
        TX_STOP: begin
          // Bit counter is reused to count stop-bit periods.
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud <= '0;
            if (r_tx_bits == STOP_LAST) begin
              r_tx_bits  <= '0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_bits <= r_tx_bits + BW'(1);
            end
          end else begin
            r_tx_baud <= r_tx_baud + CW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Loopback only changes while both directions are idle; RX source is synchronised.
  assign w_rx_src = r_loopback ? r_tx_line : rx_pin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loopback <= 1'b0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
    end else begin
      r_sync1 <= w_rx_src;
      r_sync2 <= r_sync1;
      if ((r_tx_state == TX_IDLE) && (r_rx_state == RX_IDLE)) begin
        r_loopback <= loopback;
      end
    end
  end

  // Receiver: all samples are spaced a whole bit from the mid-start point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_baud    <= '0;
      r_rx_bits    <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_data    <= '0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_done    <= 1'b0;
      r_rx_valid   <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_done;
      r_rx_done  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_sync2) begin
            r_rx_baud  <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_baud <= r_rx_baud + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bits == DATA_LAST) begin
              r_rx_bits  <= '0;
              r_rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              r_rx_bits <= r_rx_bits + BW'(1);
            end
          end else begin
            r_rx_baud <= r_rx_baud + CW'(1);
          end
        end
        RX_PARITY: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud    <= '0;
            r_rx_par_bit <= r_sync2;
            r_rx_state   <= RX_STOP;
          end else begin
            r_rx_baud <= r_rx_baud + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_data  <= r_rx_shift;
            r_rx_perr  <= (PARITY != PAR_NONE) &&
                          (r_rx_par_bit != parity_bit(w_rx_ext, DATA_BITS, PARITY));
            r_rx_ferr  <= !r_sync2;
            r_rx_done  <= 1'b1;
            // A low stop (frame error or break) must return high before re-arming.
            r_rx_state <= r_sync2 ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            r_rx_baud <= r_rx_baud + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (r_sync2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - self-checking bench for uart_core_param
module tb_uart_core_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: 8N1, instance b: 7E1, instance c: 8O1; all 8 clocks per bit.
  logic       rx_a = 1'b1, tx_pin_a, tx_valid_a = 1'b0, tx_ready_a, tx_busy_a, loop_a = 1'b0;
  logic [7:0] tx_data_a = '0, rx_data_a;
  logic       rx_valid_a, perr_a, ferr_a;

  logic       rx_b = 1'b1, tx_pin_b, tx_valid_b = 1'b0, tx_ready_b, tx_busy_b, loop_b = 1'b0;
  logic [6:0] tx_data_b = '0, rx_data_b;
  logic       rx_valid_b, perr_b, ferr_b;

  logic       rx_c = 1'b1, tx_pin_c, tx_valid_c = 1'b0, tx_ready_c, tx_busy_c, loop_c = 1'b0;
  logic [7:0] tx_data_c = '0, rx_data_c;
  logic       rx_valid_c, perr_c, ferr_c;

  uart_core_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TX_FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rx_pin(rx_a), .tx_pin(tx_pin_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_busy(tx_busy_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .loopback(loop_a));

  uart_core_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .TX_FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rx_pin(rx_b), .tx_pin(tx_pin_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_busy(tx_busy_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .loopback(loop_b));

  uart_core_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .TX_FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .rx_pin(rx_c), .tx_pin(tx_pin_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_busy(tx_busy_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .loopback(loop_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard records: {data[8:0], parity_err, frame_err}
  logic [10:0] exp_a[$], got_a[$], exp_c[$], got_c[$];
  logic [7:0]  tx_exp[$], txw_q[$];
  int          txt_q[$];
  logic        txs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: bit 0 = start, data LSB first, optional parity, stop.
  function automatic logic [11:0] mk_frame(input logic [8:0] d, input int nbits, input int mode);
    logic [11:0] f;
    logic        x;
    f    = '1;
    f[0] = 1'b0;
    x    = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      f[i+1] = d[i];
      x      = x ^ d[i];
    end
    if (mode != 0) f[nbits+1] = (mode == 1) ? ~x : x;
    return f;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel == 0) ? u_a.r_tx_line : tx_pin_b;
  endfunction

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_c = v;
  endtask

  task automatic drive_rx(input int sel, input logic [8:0] d, input int nbits, input int mode,
                          input logic flip_par, input logic stop_val, input int stop_cycles);
    logic [11:0] f;
    int          n;
    f = mk_frame(d, nbits, mode);
    n = 2 + nbits + ((mode != 0) ? 1 : 0);
    if (flip_par && mode != 0) f[nbits+1] = ~f[nbits+1];
    f[n-1] = stop_val;
    for (int k = 0; k < n; k++) begin
      set_rx(sel, f[k]);
      repeat ((k == n - 1) ? stop_cycles : 8) @(negedge clk);
    end
    set_rx(sel, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  task automatic capture(input int sel, output logic [9:0] bits);
    int t;
    t    = 0;
    bits = '1;
    while (line_of(sel) !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("capture_start_seen", t < 100, 1);
    if (t < 100) begin
      repeat (3) @(negedge clk);
      bits[0] = line_of(sel);
      for (int k = 1; k < 10; k++) begin
        repeat (8) @(negedge clk);
        bits[k] = line_of(sel);
      end
    end
  endtask

  task automatic wait_check_rx(input int sel, input string tag);
    logic [10:0] g, e;
    int          t;
    t = 0;
    while (((sel == 0) ? got_a.size() : got_c.size()) == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rx_valid_seen"}, t < 400, 1);
    if (t < 400) begin
      if (sel == 0) begin g = got_a.pop_front(); e = exp_a.pop_front(); end
      else begin g = got_c.pop_front(); e = exp_c.pop_front(); end
      check({tag, "_rx_data"}, 32'(g[10:2]), 32'(e[10:2]));
      check({tag, "_parity_err"}, g[1], e[1]);
      check({tag, "_frame_err"}, g[0], e[0]);
    end
  endtask

  // RX output monitors
  always @(negedge clk) begin
    if (rx_valid_a === 1'b1) got_a.push_back({1'b0, rx_data_a, perr_a, ferr_a});
    if (rx_valid_c === 1'b1) got_c.push_back({1'b0, rx_data_c, perr_c, ferr_c});
  end

  // 8N1 line decoder on tx_pin_a
  int         mon_t0;
  logic [7:0] mon_w;
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (tx_pin_a === 1'b0) begin
        mon_t0 = cyc;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (8) @(negedge clk);
          mon_w[k] = tx_pin_a;
        end
        repeat (8) @(negedge clk);
        txw_q.push_back(mon_w);
        txt_q.push_back(mon_t0);
        txs_q.push_back(tx_pin_a);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin : stim
    logic [9:0]  bits;
    logic [11:0] ef;
    int          acc;
    int          t;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_pin", tx_pin_a, 1);
    check("rst_tx_ready", tx_ready_a, 1);
    check("rst_tx_busy", tx_busy_a, 0);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_ferr", ferr_a, 0);

    // 1: loopback 8N1, 0xA5
    loop_a = 1'b1;
    repeat (2) @(negedge clk);
    exp_a.push_back({9'h0A5, 1'b0, 1'b0});
    tx_data_a  = 8'hA5;
    tx_valid_a = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b0;
    capture(0, bits);
    ef = mk_frame(9'h0A5, 8, 0);
    check("t1_internal_bits", bits, ef[9:0]);
    wait_check_rx(0, "t1");
    repeat (20) @(negedge clk);
    check("t1_single_pulse", got_a.size(), 0);
    check("t1_tx_pin_quiet", txw_q.size(), 0);
    loop_a = 1'b0;
    repeat (4) @(negedge clk);

    // 2: 7E1 transmit of 0x07 on tx_pin
    tx_data_b  = 7'h07;
    tx_valid_b = 1'b1;
    @(negedge clk);
    tx_valid_b = 1'b0;
    capture(1, bits);
    ef = mk_frame(9'h007, 7, 2);
    check("t2_tx_bits", bits, ef[9:0]);

    // 3: odd parity, bad parity then clean frame
    exp_c.push_back({9'h03C, 1'b1, 1'b0});
    drive_rx(2, 9'h03C, 8, 1, 1'b1, 1'b1, 8);
    wait_check_rx(2, "t3_bad_par");
    exp_c.push_back({9'h03C, 1'b0, 1'b0});
    drive_rx(2, 9'h03C, 8, 1, 1'b0, 1'b1, 8);
    wait_check_rx(2, "t3_clean");

    // 4: stop bit low for 40 cycles
    exp_a.push_back({9'h055, 1'b0, 1'b1});
    drive_rx(0, 9'h055, 8, 0, 1'b0, 1'b0, 40);
    wait_check_rx(0, "t4_break");
    repeat (40) @(negedge clk);
    check("t4_no_extra_valid", got_a.size(), 0);

    // 5: 3-cycle glitch, then a valid 0x81
    set_rx(0, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    check("t5_glitch_ignored", got_a.size(), 0);
    exp_a.push_back({9'h081, 1'b0, 1'b0});
    drive_rx(0, 9'h081, 8, 0, 1'b0, 1'b1, 8);
    wait_check_rx(0, "t5_after_glitch");

    // 6: FIFO fill, back-to-back frames, reset mid-frame
    acc        = 0;
    tx_valid_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data_a = 8'(17 * (i + 1));
      if (i < 5) tx_exp.push_back(8'(17 * (i + 1)));
      if (tx_ready_a === 1'b1) acc++;
      @(negedge clk);
    end
    tx_valid_a = 1'b0;
    check("t6_accepted", acc, 5);
    check("t6_ready_low", tx_ready_a, 0);
    check("t6_busy", tx_busy_a, 1);
    t = 0;
    while (txw_q.size() < 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("t6_two_frames_seen", t < 400, 1);
    if (t < 400) begin
      check("t6_frame0", txw_q[0], tx_exp.pop_front());
      check("t6_frame1", txw_q[1], tx_exp.pop_front());
      check("t6_stop0", txs_q[0], 1);
      check("t6_period", txt_q[1] - txt_q[0], 81);
    end
    repeat (20) @(negedge clk);
    check("t6_busy_mid_frame3", tx_busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_tx_pin", tx_pin_a, 1);
    check("t6_rst_busy", tx_busy_a, 0);
    check("t6_rst_ready", tx_ready_a, 1);
    repeat (100) @(negedge clk);
    check("t6_idle_after_rst", tx_busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
